// File: rtl/pulse_meas.sv
// Measures pulseIn high time in clk cycles, rejects pulses shorter than minCount as glitches,
// and holds each accepted width behind a valid/ack handshake. Define PULSE_MEAS_SYNC_EN to add a 2-flop input synchronizer.
module pulse_meas #(
  parameter int WIDTH = 32,
  parameter int GW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulseIn,
  input  logic [WIDTH-1:0] minCount,
  input  logic             ack,
  input  logic             clearStats,
  output logic             valid,
  output logic [WIDTH-1:0] width,
  output logic             overflow,
  output logic             glitch,
  output logic [GW-1:0]    glitchCount,
  output logic             dropped,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, REPORT} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [GW-1:0]    GC_MAX  = '1;

  state_t           state, state_nxt;
  logic             pulse_s;
  logic             pulse_q;
  logic [WIDTH-1:0] count;
  logic             ovf;
  logic [WIDTH-1:0] min_eff;
  logic             accept;
  logic             load_res;
  logic             glitch_evt;

`ifdef PULSE_MEAS_SYNC_EN
  // Reset high so a line already high at reset release is not mistaken for a fresh edge.
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], pulseIn};
  end
  assign pulse_s = sync_q[1];
`else
  assign pulse_s = pulseIn;
`endif

  assign min_eff = (minCount == '0) ? WIDTH'(1) : minCount;
  assign accept  = (count >= min_eff);
  assign valid   = (state == REPORT);
  assign busy    = (state == MEASURE) || (state == REPORT);

  always_comb begin
    state_nxt  = state;
    load_res   = 1'b0;
    glitch_evt = 1'b0;
    case (state)
      IDLE:    if (!pulse_s) state_nxt = ARMED;
      ARMED:   if (pulse_s)  state_nxt = MEASURE;
      MEASURE: begin
        if (!pulse_s) begin
          if (accept) begin
            state_nxt = REPORT;
            load_res  = 1'b1;
          end else begin
            state_nxt  = ARMED;
            glitch_evt = 1'b1;
          end
        end
      end
      REPORT:  if (ack) state_nxt = pulse_s ? IDLE : ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pulse_q     <= 1'b1;
      count       <= '0;
      ovf         <= 1'b0;
      width       <= '0;
      overflow    <= 1'b0;
      glitch      <= 1'b0;
      glitchCount <= '0;
      dropped     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pulse_q <= pulse_s;
      glitch  <= glitch_evt;

      if (state == ARMED && pulse_s) begin
        count <= WIDTH'(1);
        ovf   <= 1'b0;
      end else if (state == MEASURE && pulse_s) begin
        // Saturate rather than wrap; ovf records that at least one increment was lost.
        if (count == CNT_MAX) ovf <= 1'b1;
        else                  count <= count + WIDTH'(1);
      end

      if (load_res) begin
        width    <= count;
        overflow <= ovf;
      end

      if (clearStats)
        glitchCount <= '0;
      else if (glitch_evt && glitchCount != GC_MAX)
        glitchCount <= glitchCount + GW'(1);

      if (clearStats)
        dropped <= 1'b0;
      else if (state == REPORT && pulse_s && !pulse_q)
        dropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_meas.sv
// Directed bench for pulse_meas with WIDTH=4 so saturation is reachable, GW=2 for glitch-count saturation.
module tb_pulse_meas;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulseIn;
  logic [3:0] minCount;
  logic       ack;
  logic       clearStats;
  logic       valid;
  logic [3:0] width;
  logic       overflow;
  logic       glitch;
  logic [1:0] glitchCount;
  logic       dropped;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  pulse_meas #(.WIDTH(4), .GW(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .pulseIn     (pulseIn),
    .minCount    (minCount),
    .ack         (ack),
    .clearStats  (clearStats),
    .valid       (valid),
    .width       (width),
    .overflow    (overflow),
    .glitch      (glitch),
    .glitchCount (glitchCount),
    .dropped     (dropped),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pulseIn = 1'b0; minCount = 4'd3; ack = 1'b0; clearStats = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(valid), 0);
    check("rst_width", 32'(width), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_glitch", 32'(glitch), 0);
    check("rst_gcount", 32'(glitchCount), 0);
    check("rst_dropped", 32'(dropped), 0);
    check("rst_busy", 32'(busy), 0);

    // 5-cycle pulse, minCount=3
    reset = 1'b0; tick();
    check("armed_busy", 32'(busy), 0);
    pulseIn = 1'b1; tick();
    check("meas_busy", 32'(busy), 1);
    repeat (4) tick();
    check("meas_no_valid", 32'(valid), 0);
    pulseIn = 1'b0; tick();
    check("p5_valid", 32'(valid), 1);
    check("p5_width", 32'(width), 5);
    check("p5_ovf", 32'(overflow), 0);
    tick();
    check("p5_held", 32'(valid), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("p5_ack_valid", 32'(valid), 0);
    check("p5_ack_busy", 32'(busy), 0);

    // width equal to minCount is accepted
    pulseIn = 1'b1; repeat (3) tick();
    pulseIn = 1'b0; tick();
    check("eq_valid", 32'(valid), 1);
    check("eq_width", 32'(width), 3);
    check("eq_glitch", 32'(glitch), 0);
    ack = 1'b1; tick(); ack = 1'b0;

    // glitch rejection and statistics
    minCount = 4'd4;
    pulseIn = 1'b1; repeat (2) tick();
    pulseIn = 1'b0; tick();
    check("gl_strobe", 32'(glitch), 1);
    check("gl_count", 32'(glitchCount), 1);
    check("gl_no_valid", 32'(valid), 0);
    tick();
    check("gl_strobe_off", 32'(glitch), 0);
    clearStats = 1'b1; tick(); clearStats = 1'b0;
    check("gl_cleared", 32'(glitchCount), 0);
    for (int i = 0; i < 3; i++) begin
      pulseIn = 1'b1; tick();
      pulseIn = 1'b0; tick();
    end
    check("gl_count3", 32'(glitchCount), 3);
    pulseIn = 1'b1; tick();
    pulseIn = 1'b0; tick();
    check("gl_saturated", 32'(glitchCount), 3);
    pulseIn = 1'b1; tick();
    pulseIn = 1'b0; clearStats = 1'b1; tick(); clearStats = 1'b0;
    check("gl_clr_strobe", 32'(glitch), 1);
    check("gl_clr_wins", 32'(glitchCount), 0);

    // pulse high across reset release is ignored
    reset = 1'b1; pulseIn = 1'b1; tick(); tick();
    reset = 1'b0; minCount = 4'd1;
    repeat (10) tick();
    check("hi_rst_busy", 32'(busy), 0);
    check("hi_rst_valid", 32'(valid), 0);
    pulseIn = 1'b0; tick();
    pulseIn = 1'b1; repeat (3) tick();
    pulseIn = 1'b0; tick();
    check("hi_rst_valid2", 32'(valid), 1);
    check("hi_rst_width", 32'(width), 3);
    ack = 1'b1; tick(); ack = 1'b0;

    // saturation at 15
    pulseIn = 1'b1; repeat (20) tick();
    pulseIn = 1'b0; tick();
    check("sat_width", 32'(width), 15);
    check("sat_ovf", 32'(overflow), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    pulseIn = 1'b1; repeat (15) tick();
    pulseIn = 1'b0; tick();
    check("max_width", 32'(width), 15);
    check("max_ovf", 32'(overflow), 0);
    ack = 1'b1; tick(); ack = 1'b0;

    // pulse arriving while result pending
    pulseIn = 1'b1; repeat (2) tick();
    pulseIn = 1'b0; tick();
    tick();
    check("drop_before", 32'(dropped), 0);
    pulseIn = 1'b1; tick();
    check("drop_set", 32'(dropped), 1);
    check("drop_valid", 32'(valid), 1);
    repeat (2) tick();
    pulseIn = 1'b0; tick();
    check("drop_width_kept", 32'(width), 2);
    ack = 1'b1; tick(); ack = 1'b0;
    check("drop_acked", 32'(valid), 0);
    check("drop_sticky", 32'(dropped), 1);
    pulseIn = 1'b1; repeat (4) tick();
    pulseIn = 1'b0; tick();
    check("drop_next_width", 32'(width), 4);
    check("drop_next_valid", 32'(valid), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    clearStats = 1'b1; tick(); clearStats = 1'b0;
    check("drop_cleared", 32'(dropped), 0);

    // minCount=0 accepts a single-cycle pulse
    minCount = 4'd0;
    pulseIn = 1'b1; tick();
    pulseIn = 1'b0; tick();
    check("min0_valid", 32'(valid), 1);
    check("min0_width", 32'(width), 1);
    ack = 1'b1; tick(); ack = 1'b0;

    // reset mid-measure abandons the pulse
    minCount = 4'd4;
    pulseIn = 1'b1; repeat (2) tick();
    pulseIn = 1'b0; reset = 1'b1; tick();
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_glitch", 32'(glitch), 0);
    check("mid_rst_busy", 32'(busy), 0);
    reset = 1'b0; tick(); tick();
    check("mid_rst_glitch2", 32'(glitch), 0);
    check("mid_rst_valid2", 32'(valid), 0);
    check("mid_rst_gcount", 32'(glitchCount), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
